// File: rtl/sum35_sched_if.sv
// Scheduler bus: requester handshake, engine start/busy handshake and tagged result.
// master = requesters + engine environment, slave = sum35_sched.
interface sum35_sched_if #(
  parameter int NREQ = 4,
  parameter int NW   = 16,
  parameter int RW   = 32
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req;
  logic [NREQ*NW-1:0] req_n;
  logic [NREQ-1:0]    ack;
  logic               eng_st;
  logic [NW-1:0]      eng_in;
  logic               eng_busy;
  logic [RW-1:0]      eng_sum;
  logic               done;
  logic [IDW-1:0]     done_id;
  logic [RW-1:0]      result;
  logic               err;
  logic               sched_busy;

  modport master (
    output req, req_n, eng_busy, eng_sum,
    input  ack, eng_st, eng_in, done, done_id, result, err, sched_busy
  );

  modport slave (
    input  req, req_n, eng_busy, eng_sum,
    output ack, eng_st, eng_in, done, done_id, result, err, sched_busy
  );
endinterface

// File: rtl/sum35_sched.sv
// Round-robin scheduler sharing one sum-of-multiples-of-3-or-5 engine between NREQ requesters.
// Optional watchdog abort on a stuck engine: define SUM35_WATCHDOG_EN.
//
// state | meaning
// IDLE  | wait for a request while the engine is idle, pick winner from rr_ptr
// GRANT | ack winner, latch operand; N<3 bypasses the engine
// ISSUE | one-cycle engine start pulse
// ACK   | wait for engine busy to rise
// RUN   | wait for engine busy to fall, capture sum
// DONE  | publish result, advance rr_ptr
module sum35_sched #(
  parameter int NREQ = 4,
  parameter int NW   = 16,
  parameter int RW   = 32,
  parameter int TMO  = 1023
) (
  input logic         clk,
  input logic         rst,
  sum35_sched_if.slave bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_ISSUE, S_ACK, S_RUN, S_DONE
  } state_t;

  state_t         state, state_nx;
  logic [IDW-1:0] rr_ptr, cur_id, win_id, scan_id, done_id_q;
  logic           win_vld;
  logic [NW-1:0]  ops [NREQ];
  logic [NW-1:0]  op_sel, eng_in_q;
  logic [RW-1:0]  result_q;
  logic           wd_hit;
  logic           enter_done;

  for (genvar g = 0; g < NREQ; g++) begin : g_op
    assign ops[g] = bus.req_n[g*NW +: NW];
  end

  assign op_sel     = ops[cur_id];
  assign enter_done = (state_nx == S_DONE) && (state != S_DONE);

  // Circular search for the first set request at or after rr_ptr
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    scan_id = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_id = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!win_vld && bus.req[scan_id]) begin
        win_vld = 1'b1;
        win_id  = scan_id;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (win_vld && !bus.eng_busy) state_nx = S_GRANT;
      S_GRANT: state_nx = (op_sel < NW'(3)) ? S_DONE : S_ISSUE;
      S_ISSUE: state_nx = S_ACK;
      S_ACK: begin
        if (bus.eng_busy)  state_nx = S_RUN;
        else if (wd_hit)   state_nx = S_DONE;
      end
      S_RUN:   if (!bus.eng_busy || wd_hit) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      cur_id    <= '0;
      eng_in_q  <= '0;
      result_q  <= '0;
      done_id_q <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && state_nx == S_GRANT) cur_id <= win_id;
      if (state == S_GRANT) eng_in_q <= op_sel;
      // Only a normal RUN completion carries a sum; bypass and abort report 0
      if (enter_done) begin
        done_id_q <= cur_id;
        result_q  <= (state == S_RUN && !bus.eng_busy) ? bus.eng_sum : '0;
      end
      if (state == S_DONE)
        rr_ptr <= (cur_id == IDW'(NREQ-1)) ? '0 : cur_id + 1'b1;
    end
  end

`ifdef SUM35_WATCHDOG_EN
  localparam int CW = ($clog2(TMO+1) > 10) ? $clog2(TMO+1) : 10;
  logic [CW-1:0] wd_cnt;
  logic          err_q;

  // Abort on the cycle the count would reach TMO
  assign wd_hit = (state == S_ACK || state == S_RUN) && (wd_cnt == CW'(TMO-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == S_ISSUE) wd_cnt <= '0;
      else if (state == S_ACK || state == S_RUN) wd_cnt <= wd_cnt + 1'b1;
      if (enter_done)
        err_q <= (state == S_ACK) || (state == S_RUN && bus.eng_busy);
    end
  end

  assign bus.err = (state == S_DONE) && err_q;
`else
  assign wd_hit  = 1'b0;
  assign bus.err = 1'b0;
`endif

  assign bus.ack        = (state == S_GRANT) ? (NREQ'(1) << cur_id) : '0;
  assign bus.eng_st     = (state == S_ISSUE);
  assign bus.eng_in     = eng_in_q;
  assign bus.done       = (state == S_DONE);
  assign bus.done_id    = done_id_q;
  assign bus.result     = result_q;
  assign bus.sched_busy = (state != S_IDLE);
endmodule

// File: tb/tb_sum35_sched.sv
// Directed bench for sum35_sched with a behavioural engine (busy for a few cycles, then sum).
// Watchdog scenario runs only when SUM35_WATCHDOG_EN is defined.
module tb_sum35_sched;
  localparam int NREQ = 4;
  localparam int NW   = 16;
  localparam int RW   = 32;
`ifdef SUM35_WATCHDOG_EN
  localparam int TMO_P = 20;
`else
  localparam int TMO_P = 1023;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  sum35_sched_if #(.NREQ(NREQ), .NW(NW), .RW(RW)) bus ();

  sum35_sched #(.NREQ(NREQ), .NW(NW), .RW(RW), .TMO(TMO_P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Engine model: busy from the cycle after eng_st for a few cycles
  logic          eng_run   = 1'b0;
  int            eng_cnt   = 0;
  logic [RW-1:0] eng_sum_r = '0;
  logic          eng_hang  = 1'b0;
  logic          eng_hold  = 1'b0;

  function automatic logic [RW-1:0] sum35(input logic [NW-1:0] n);
    logic [RW-1:0] s = '0;
    for (int i = 0; i < int'(n); i++)
      if (i % 3 == 0 || i % 5 == 0) s += RW'(i);
    return s;
  endfunction

  always @(posedge clk) begin
    if (bus.eng_st && !eng_hang) begin
      eng_run   <= 1'b1;
      eng_cnt   <= 3;
      eng_sum_r <= sum35(bus.eng_in);
    end else if (eng_run) begin
      if (eng_cnt == 0) eng_run <= 1'b0;
      else eng_cnt <= eng_cnt - 1;
    end
  end

  assign bus.eng_busy = eng_run | eng_hold;
  assign bus.eng_sum  = eng_sum_r;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise one request, step into GRANT, then drop it
  task automatic issue(input int id, input logic [NW-1:0] n);
    bus.req_n[id*NW +: NW] = n;
    bus.req[id] = 1'b1;
    tick();
    bus.req[id] = 1'b0;
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    while (!bus.done && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.ack !== 4'b0000 || bus.eng_st !== 1'b0 || bus.done !== 1'b0 ||
        bus.err !== 1'b0 || bus.sched_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl ack=%b eng_st=%b done=%b err=%b busy=%b, want all 0",
               bus.ack, bus.eng_st, bus.done, bus.err, bus.sched_busy);
    end
    checks++;
    if (bus.eng_in !== '0 || bus.done_id !== '0 || bus.result !== '0) begin
      errors++;
      $display("FAIL reset_data eng_in=%0d done_id=%0d result=%0d, want 0",
               bus.eng_in, bus.done_id, bus.result);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int n;
    issue(1, 16'd10);
    checks++;
    if (bus.ack !== 4'b0010 || bus.sched_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_ack ack=%b busy=%b, want 0010/1", bus.ack, bus.sched_busy);
    end
    tick();
    checks++;
    if (bus.eng_st !== 1'b1 || bus.eng_in !== 16'd10 || bus.ack !== 4'b0000) begin
      errors++;
      $display("FAIL single_issue eng_st=%b eng_in=%0d ack=%b, want 1/10/0000",
               bus.eng_st, bus.eng_in, bus.ack);
    end
    tick();
    checks++;
    if (bus.eng_st !== 1'b0) begin
      errors++;
      $display("FAIL single_st_pulse eng_st=%b, want 0", bus.eng_st);
    end
    wait_done(50, n);
    checks++;
    if (bus.done !== 1'b1 || bus.done_id !== 2'd1 || bus.result !== 32'd23 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL single_done done=%b id=%0d result=%0d err=%b, want 1/1/23/0",
               bus.done, bus.done_id, bus.result, bus.err);
    end
    tick();
  endtask

  task automatic test_n16();
    logic prev_busy;
    int   fall_at = -1;
    int   done_at = -1;
    bit   in_bad  = 1'b0;
    issue(0, 16'd16);
    tick();
    prev_busy = bus.eng_busy;
    for (int i = 0; i < 50 && done_at < 0; i++) begin
      tick();
      if (bus.done) done_at = i;
      else begin
        if (bus.eng_in !== 16'd16) in_bad = 1'b1;
        if (prev_busy && !bus.eng_busy) fall_at = i;
        prev_busy = bus.eng_busy;
      end
    end
    checks++;
    if (in_bad) begin
      errors++;
      $display("FAIL n16_eng_in_stable eng_in=%0d, want 16 throughout", bus.eng_in);
    end
    checks++;
    if (done_at < 0 || fall_at < 0 || done_at != fall_at + 1) begin
      errors++;
      $display("FAIL n16_latency done_at=%0d busy_fall_at=%0d, want done one cycle after fall",
               done_at, fall_at);
    end
    checks++;
    if (bus.result !== 32'd60 || bus.done_id !== 2'd0) begin
      errors++;
      $display("FAIL n16_result result=%0d id=%0d, want 60/0", bus.result, bus.done_id);
    end
    tick();
    checks++;
    if (bus.sched_busy !== 1'b0) begin
      errors++;
      $display("FAIL n16_busy_fall sched_busy=%b, want 0", bus.sched_busy);
    end
  endtask

  task automatic test_bypass();
    int st_seen = 0;
    issue(3, 16'd2);
    if (bus.eng_st) st_seen++;
    checks++;
    if (bus.ack !== 4'b1000) begin
      errors++;
      $display("FAIL bypass_ack ack=%b, want 1000", bus.ack);
    end
    tick();
    if (bus.eng_st) st_seen++;
    checks++;
    if (bus.done !== 1'b1 || bus.done_id !== 2'd3 || bus.result !== 32'd0) begin
      errors++;
      $display("FAIL bypass_done done=%b id=%0d result=%0d, want 1/3/0",
               bus.done, bus.done_id, bus.result);
    end
    tick();
    if (bus.eng_st) st_seen++;
    checks++;
    if (st_seen != 0) begin
      errors++;
      $display("FAIL bypass_no_start eng_st seen %0d times, want 0", st_seen);
    end
  endtask

  task automatic test_round_robin();
    int            n;
    logic [1:0]    exp_id  [4] = '{2'd0, 2'd2, 2'd0, 2'd2};
    logic [RW-1:0] exp_res [4] = '{32'd45, 32'd78, 32'd45, 32'd78};
    bus.req_n[0*NW +: NW] = 16'd15;
    bus.req_n[2*NW +: NW] = 16'd20;
    bus.req = 4'b0101;
    for (int j = 0; j < 4; j++) begin
      wait_done(60, n);
      checks++;
      if (bus.done !== 1'b1 || bus.done_id !== exp_id[j] || bus.result !== exp_res[j]) begin
        errors++;
        $display("FAIL rr_job%0d done=%b id=%0d result=%0d, want 1/%0d/%0d",
                 j, bus.done, bus.done_id, bus.result, exp_id[j], exp_res[j]);
      end
      if (j == 3) bus.req = 4'b0000;
      tick();
    end
    bus.req = 4'b0100;
    wait_done(60, n);
    bus.req = 4'b0000;
    checks++;
    if (bus.done !== 1'b1 || bus.done_id !== 2'd2 || bus.result !== 32'd78) begin
      errors++;
      $display("FAIL rr_wrap done=%b id=%0d result=%0d, want 1/2/78",
               bus.done, bus.done_id, bus.result);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int n;
    bit early_ack = 1'b0;
    issue(1, 16'd10);
    for (n = 0; n < 20 && !bus.eng_busy; n++) tick();
    tick();
    eng_hold = 1'b1;
    rst = 1'b1;
    tick();
    checks++;
    if (bus.ack !== 4'b0000 || bus.eng_st !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 ||
        bus.sched_busy !== 1'b0 || bus.eng_in !== '0 || bus.done_id !== '0 || bus.result !== '0) begin
      errors++;
      $display("FAIL midrun_reset ack=%b st=%b done=%b err=%b busy=%b in=%0d id=%0d res=%0d, want all 0",
               bus.ack, bus.eng_st, bus.done, bus.err, bus.sched_busy, bus.eng_in,
               bus.done_id, bus.result);
    end
    rst = 1'b0;
    bus.req_n[1*NW +: NW] = 16'd10;
    bus.req[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.ack !== 4'b0000 || bus.sched_busy !== 1'b0) early_ack = 1'b1;
    end
    checks++;
    if (early_ack) begin
      errors++;
      $display("FAIL midrun_hold granted while engine busy ack=%b, want no grant", bus.ack);
    end
    eng_hold = 1'b0;
    for (n = 0; n < 10 && bus.ack === 4'b0000; n++) tick();
    checks++;
    if (bus.ack !== 4'b0010) begin
      errors++;
      $display("FAIL midrun_grant ack=%b, want 0010", bus.ack);
    end
    bus.req[1] = 1'b0;
    wait_done(60, n);
    checks++;
    if (bus.done !== 1'b1 || bus.done_id !== 2'd1 || bus.result !== 32'd23) begin
      errors++;
      $display("FAIL midrun_done done=%b id=%0d result=%0d, want 1/1/23",
               bus.done, bus.done_id, bus.result);
    end
    tick();
  endtask

`ifdef SUM35_WATCHDOG_EN
  task automatic test_watchdog();
    int n;
    eng_hang = 1'b1;
    issue(0, 16'd10);
    tick();
    checks++;
    if (bus.eng_st !== 1'b1) begin
      errors++;
      $display("FAIL wd_start eng_st=%b, want 1", bus.eng_st);
    end
    wait_done(100, n);
    checks++;
    if (bus.done !== 1'b1 || n != 21 || bus.err !== 1'b1 || bus.result !== 32'd0) begin
      errors++;
      $display("FAIL wd_abort done=%b cycles=%0d err=%b result=%0d, want 1/21/1/0",
               bus.done, n, bus.err, bus.result);
    end
    tick();
    eng_hang = 1'b0;
    issue(0, 16'd10);
    wait_done(60, n);
    checks++;
    if (bus.done !== 1'b1 || bus.err !== 1'b0 || bus.result !== 32'd23) begin
      errors++;
      $display("FAIL wd_recover done=%b err=%b result=%0d, want 1/0/23",
               bus.done, bus.err, bus.result);
    end
    tick();
  endtask
`endif

  initial begin
    bus.req   = '0;
    bus.req_n = '0;
    test_reset();
    test_single();
    test_n16();
    test_bypass();
    test_round_robin();
    test_reset_mid_run();
`ifdef SUM35_WATCHDOG_EN
    test_watchdog();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end
endmodule
